dispense_scheduler: RTL and testbench

DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

---
 rtl/dispense_pkg.sv | 33 +++
 rtl/dispense_scheduler_drop_sync.sv | 26 ++
 rtl/dispense_scheduler.sv | 173 +++++++++++++++++
 tb/tb_dispense_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// Shared types and defaults for the pill dispense scheduler: FSM states, slot codes, timing defaults.
// Pure declarations; no latency, no backpressure.
package dispense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DRIVE,
    ST_WAIT_DROP,
    ST_DONE
  } state_t;

  localparam logic [1:0] SLOT_MORNING   = 2'd0;
  localparam logic [1:0] SLOT_AFTERNOON = 2'd1;
  localparam logic [1:0] SLOT_EVENING   = 2'd2;

  localparam int unsigned DEF_MOTOR_CYCLES   = 25_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;
  localparam int unsigned DEF_MAX_RETRY      = 2;

  // Lowest pending slot of one dispenser; caller guarantees req is non-zero.
  function automatic logic [1:0] lowest_slot(input logic [2:0] req);
    if (req[0]) return SLOT_MORNING;
    if (req[1]) return SLOT_AFTERNOON;
    return SLOT_EVENING;
  endfunction

  // Bit position of (dispenser, slot) in the 6-bit pending vector.
  function automatic logic [2:0] pend_idx(input logic d, input logic [1:0] s);
    return d ? (3'(s) + 3'd3) : 3'(s);
  endfunction

endpackage

// File: rtl/dispense_scheduler_drop_sync.sv
// Two-flop synchronizer plus rising-edge detect for one pill-drop sensor.
// Latency: edge pulse visible 3 cycles after the input rises; no backpressure.
module drop_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise_p
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      rise_p <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Two-dispenser, three-slot pill scheduler: round-robin grant, timed motor drive, drop confirm with retry/fault.
// Latency: grant 2 cycles after a pending bit appears; no backpressure, extra dose pulses raise overrun.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES   = DEF_MOTOR_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       morning_p,
  input  logic       afternoon_p,
  input  logic       evening_p,
  input  logic [5:0] slot_mask,
  input  logic [1:0] drop_sense,
  input  logic       fault_clr,
  output logic [1:0] motor,
  output logic       busy,
  output logic       dispensed_p,
  output logic       last_disp,
  output logic [1:0] last_slot,
  output logic [1:0] fault,
  output logic       overrun
);

  localparam int unsigned CNT_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] MOTOR_LAST   = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] RETRY_LIM    = AW'(MAX_RETRY);

  state_t          state;
  logic [5:0]      pending;
  logic            gnt_d;
  logic [1:0]      gnt_s;
  logic            rr_last;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   attempt;
  logic            seen;
  logic [1:0]      drop_edge;

  logic [2:0]      dose;
  logic [5:0]      set_req, clr_req, wipe, hit, pending_nxt;
  logic            has0, has1, sel_d;
  logic [1:0]      sel_s;
  logic            edge_g, tmo_exp, give_up;
  logic [1:0]      fault_set;

  for (genvar d = 0; d < 2; d++) begin : g_sync
    drop_sync u_drop_sync (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .din    (drop_sense[d]),
      .rise_p (drop_edge[d])
    );
  end

  assign dose    = {evening_p, afternoon_p, morning_p};
  assign edge_g  = drop_edge[gnt_d];
  assign tmo_exp = (state == ST_WAIT_DROP) && !(seen || edge_g) && (cnt == TIMEOUT_LAST);
  assign give_up = tmo_exp && (attempt >= RETRY_LIM);
  assign fault_set = give_up ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;

  // Round-robin only matters when both dispensers have work; rr_last resets to 1 so dispenser 0 goes first.
  assign has0  = |pending[2:0];
  assign has1  = |pending[5:3];
  assign sel_d = (has0 && has1) ? ~rr_last : has1;
  assign sel_s = lowest_slot(sel_d ? pending[5:3] : pending[2:0]);

  always_comb begin
    set_req = '0;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) begin
        set_req[d*3+s] = dose[s] & slot_mask[d*3+s] & ~fault[d];
      end
    end
    clr_req = '0;
    if (state == ST_DONE) clr_req[pend_idx(gnt_d, gnt_s)] = 1'b1;
    wipe = '0;
    if (give_up) wipe = gnt_d ? 6'b111000 : 6'b000111;
  end

  // A pulse landing on the bit DONE is clearing re-arms it and is not an overrun.
  assign hit         = set_req & pending & ~clr_req;
  assign pending_nxt = ((pending & ~clr_req) | set_req) & ~wipe;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pending     <= '0;
      gnt_d       <= 1'b0;
      gnt_s       <= SLOT_MORNING;
      rr_last     <= 1'b1;
      cnt         <= '0;
      attempt     <= '0;
      seen        <= 1'b0;
      motor       <= 2'b00;
      dispensed_p <= 1'b0;
      last_disp   <= 1'b0;
      last_slot   <= SLOT_MORNING;
      fault       <= 2'b00;
      overrun     <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      overrun     <= (overrun & ~fault_clr) | (|hit);
      fault       <= (fault & ~{2{fault_clr}}) | fault_set;
      dispensed_p <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state <= ST_SELECT;
            cnt   <= '0;
          end
        end
        ST_SELECT: begin
          gnt_d   <= sel_d;
          gnt_s   <= sel_s;
          rr_last <= sel_d;
          seen    <= 1'b0;
          attempt <= '0;
          cnt     <= '0;
          motor   <= sel_d ? 2'b10 : 2'b01;
          state   <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (edge_g) seen <= 1'b1;
          if (cnt == MOTOR_LAST) begin
            motor <= 2'b00;
            cnt   <= '0;
            state <= ST_WAIT_DROP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DROP: begin
          if (seen || edge_g) begin
            dispensed_p <= 1'b1;
            last_disp   <= gnt_d;
            last_slot   <= gnt_s;
            cnt         <= '0;
            state       <= ST_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (attempt < RETRY_LIM) begin
              attempt <= attempt + 1'b1;
              motor   <= gnt_d ? 2'b10 : 2'b01;
              state   <= ST_DRIVE;
            end else begin
              attempt <= '0;
              state   <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          attempt <= '0;
          seen    <= 1'b0;
          cnt     <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          motor <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler with short timing parameters and a dispense/motor-run scoreboard.
module tb_dispense_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       morning_p, afternoon_p, evening_p;
  logic [5:0] slot_mask;
  logic [1:0] drop_sense;
  logic       fault_clr;
  logic [1:0] motor;
  logic       busy, dispensed_p, last_disp, overrun;
  logic [1:0] last_slot, fault;

  int tests = 0;
  int fails = 0;

  logic [1:0] drop_en = 2'b00;
  logic [2:0] exp_disp[$], got_disp[$];
  logic [9:0] exp_run[$], got_run[$];
  int         run_len = 0;
  logic [1:0] run_bits = 2'b00;
  int         both_on = 0;

  always #5 clk = ~clk;

  dispense_scheduler #(
    .MOTOR_CYCLES   (4),
    .TIMEOUT_CYCLES (8),
    .MAX_RETRY      (2)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .morning_p   (morning_p),
    .afternoon_p (afternoon_p),
    .evening_p   (evening_p),
    .slot_mask   (slot_mask),
    .drop_sense  (drop_sense),
    .fault_clr   (fault_clr),
    .motor       (motor),
    .busy        (busy),
    .dispensed_p (dispensed_p),
    .last_disp   (last_disp),
    .last_slot   (last_slot),
    .fault       (fault),
    .overrun     (overrun)
  );

  // Observe motor run lengths and confirmed dispenses.
  always @(negedge clk) begin
    if (!resetn) begin
      run_len = 0;
    end else begin
      if (motor == 2'b11) both_on++;
      if (motor != 2'b00) begin
        run_len++;
        run_bits = motor;
      end else if (run_len != 0) begin
        got_run.push_back({run_bits, run_len[7:0]});
        run_len = 0;
      end
      if (dispensed_p) got_disp.push_back({last_disp, last_slot});
    end
  end

  // Pill model: an enabled dispenser drops a pill shortly after its motor stops.
  initial begin
    logic [1:0] prev_m;
    logic [1:0] fell;
    prev_m = 2'b00;
    drop_sense = 2'b00;
    forever begin
      @(negedge clk);
      fell = prev_m & ~motor & drop_en;
      prev_m = motor;
      if (fell != 2'b00) begin
        repeat (2) @(negedge clk);
        drop_sense = fell;
        repeat (2) @(negedge clk);
        drop_sense = 2'b00;
        prev_m = motor;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    exp_disp.delete(); got_disp.delete();
    exp_run.delete();  got_run.delete();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_dose(input logic [2:0] d);
    {evening_p, afternoon_p, morning_p} = d;
    @(negedge clk);
    {evening_p, afternoon_p, morning_p} = 3'b000;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 12 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check({tag, "_idle_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic [2:0] e, g;
    logic [9:0] er, gr;
    check({tag, "_ndisp"}, got_disp.size(), exp_disp.size());
    while (exp_disp.size() > 0 && got_disp.size() > 0) begin
      e = exp_disp.pop_front();
      g = got_disp.pop_front();
      check({tag, "_disp_slot"}, 32'(g), 32'(e));
    end
    check({tag, "_nruns"}, got_run.size(), exp_run.size());
    while (exp_run.size() > 0 && got_run.size() > 0) begin
      er = exp_run.pop_front();
      gr = got_run.pop_front();
      check({tag, "_motor_run"}, 32'(gr), 32'(er));
    end
    exp_disp.delete(); got_disp.delete();
    exp_run.delete();  got_run.delete();
  endtask

  initial begin
    int n;
    int busy_cnt;
    resetn = 1'b0;
    {evening_p, afternoon_p, morning_p} = 3'b000;
    slot_mask = 6'b000000;
    fault_clr = 1'b0;

    // Reset state
    do_reset();
    check("rst_motor", 32'(motor), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dispensed", 32'(dispensed_p), 32'd0);
    check("rst_last", 32'({last_disp, last_slot}), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Single dispense, dispenser 0 morning
    slot_mask = 6'b000001;
    drop_en = 2'b01;
    exp_disp.push_back({1'b0, 2'd0});
    exp_run.push_back({2'b01, 8'd4});
    pulse_dose(3'b001);
    wait_idle("single", 300);
    drain("single");
    check("single_last_disp", 32'(last_disp), 32'd0);
    check("single_last_slot", 32'(last_slot), 32'd0);

    // Dispenser 0 never drops: three attempts, fault, then dispenser 1 served
    do_reset();
    slot_mask = 6'b001001;
    drop_en = 2'b10;
    repeat (3) exp_run.push_back({2'b01, 8'd4});
    exp_run.push_back({2'b10, 8'd4});
    exp_disp.push_back({1'b1, 2'd0});
    pulse_dose(3'b001);
    wait_idle("retry", 600);
    drain("retry");
    check("retry_fault", 32'(fault), 32'b01);
    check("retry_last_disp", 32'(last_disp), 32'd1);
    // Faulted dispenser must ignore new doses
    exp_run.push_back({2'b10, 8'd4});
    exp_disp.push_back({1'b1, 2'd0});
    pulse_dose(3'b001);
    wait_idle("faulted", 300);
    drain("faulted");
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_clr", 32'(fault), 32'b00);

    // Both slots of both dispensers pending: round-robin, lowest slot first
    do_reset();
    slot_mask = 6'b111111;
    drop_en = 2'b11;
    exp_disp.push_back({1'b0, 2'd0});
    exp_disp.push_back({1'b1, 2'd0});
    exp_disp.push_back({1'b0, 2'd2});
    exp_disp.push_back({1'b1, 2'd2});
    exp_run.push_back({2'b01, 8'd4});
    exp_run.push_back({2'b10, 8'd4});
    exp_run.push_back({2'b01, 8'd4});
    exp_run.push_back({2'b10, 8'd4});
    pulse_dose(3'b101);
    wait_idle("rr", 800);
    drain("rr");
    check("rr_overrun", 32'(overrun), 32'd0);

    // Overrun on repeated dose, cleared by fault_clr; dose during DONE re-arms without overrun
    do_reset();
    slot_mask = 6'b000001;
    drop_en = 2'b01;
    exp_disp.push_back({1'b0, 2'd0});
    exp_disp.push_back({1'b0, 2'd0});
    exp_run.push_back({2'b01, 8'd4});
    exp_run.push_back({2'b01, 8'd4});
    pulse_dose(3'b001);
    pulse_dose(3'b001);
    check("overrun_set", 32'(overrun), 32'd1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);
    n = 0;
    while (!dispensed_p && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(dispensed_p), 32'd1);
    pulse_dose(3'b001);
    check("done_set_no_overrun", 32'(overrun), 32'd0);
    wait_idle("reissue", 400);
    drain("reissue");
    check("reissue_overrun", 32'(overrun), 32'd0);

    // Reset while the motor is running
    do_reset();
    slot_mask = 6'b000001;
    drop_en = 2'b01;
    pulse_dose(3'b001);
    n = 0;
    while (motor != 2'b01 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drive_reached", 32'(motor), 32'b01);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_motor_off", 32'(motor), 32'd0);
    check("async_busy_off", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    exp_disp.delete(); got_disp.delete();
    exp_run.delete();  got_run.delete();
    resetn = 1'b1;
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || motor != 2'b00) busy_cnt++;
    end
    check("post_reset_idle", 32'(busy_cnt), 32'd0);
    check("post_reset_no_disp", got_disp.size(), 32'd0);

    check("motor_onehot", 32'(both_on), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
